axi_spill_cut_intf: RTL and testbench

// - Fully registered timing cut for an AXI_BUS link. Sits directly upstream of the axi_join_intf connector.
// - Breaks every combinational path (valid, ready, payload) on all five channels: AW, W, B, AR, R.
// - Each channel uses one two-entry spill register. Throughput is 1 beat/cycle; forward latency is exactly 1 cycle.

---
 rtl/axi_spill_cut_intf_if.sv | 94 +++++++++
 rtl/axi_spill_cut_intf.sv | 260 ++++++++++++++++++++++++++
 tb/tb_axi_spill_cut_intf.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_spill_cut_intf_if.sv
// AXI_BUS: AXI4 link bundle (AW, W, B, AR, R) shared by axi_spill_cut_intf
// and its neighbours.
//   Master modport: drives AW/W/AR and the B/R ready signals.
//   Slave modport : drives B/R and the AW/W/AR ready signals.
// Parameters: AXI_ADDR_WIDTH, AXI_DATA_WIDTH (strb = data/8), AXI_ID_WIDTH,
// AXI_USER_WIDTH.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_spill_cut_intf.sv
// axi_spill_cut_intf: fully registered timing cut for an AXI_BUS link.
// Every channel (AW, W, AR forward; B, R backward) passes through a
// two-entry spill register, so valid, ready and payload are all driven
// from flops on both sides. 1 beat/cycle throughput, 1 cycle latency.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      synchronous active-low reset (clears occupancy, not payload)
//   in          AXI_BUS.Slave  upstream side
//   out         AXI_BUS.Master downstream side
//   wr_outst_o  AW beats sent at out whose B has not yet been taken at in
//   rd_outst_o  AR beats sent at out whose last R has not yet been taken at in
//
// Optional feature: define AXI_SPILL_CUT_CNT_EN to enable the saturating
// outstanding-transaction counters; otherwise both counter outputs are 0.

// Two-entry spill register. Slot A feeds the output, slot B absorbs the beat
// that arrives while A is stalled. Ready is derived only from local state.
module axi_spill_cut_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         src_valid_i,
    output logic         src_ready_o,
    input  logic [W-1:0] src_data_i,
    output logic         dst_valid_o,
    input  logic         dst_ready_i,
    output logic [W-1:0] dst_data_o
);
    // EMPTY: nothing held; ONE: A holds a beat; FULL: A and B both hold beats.
    typedef enum logic [1:0] {
        SPILL_EMPTY = 2'd0,
        SPILL_ONE   = 2'd1,
        SPILL_FULL  = 2'd2
    } spill_state_e;

    spill_state_e state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic         accept;
    logic         drain;

    assign src_ready_o = (state_q != SPILL_FULL);
    assign dst_valid_o = (state_q != SPILL_EMPTY);
    assign dst_data_o  = a_q;
    assign accept      = src_valid_i & src_ready_o;
    assign drain       = dst_valid_o & dst_ready_i;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            SPILL_EMPTY: begin
                if (accept) begin
                    a_d     = src_data_i;
                    state_d = SPILL_ONE;
                end
            end
            SPILL_ONE: begin
                if (accept && drain) begin
                    // A hands its beat off and takes the new one in the same edge.
                    a_d = src_data_i;
                end else if (accept) begin
                    b_d     = src_data_i;
                    state_d = SPILL_FULL;
                end else if (drain) begin
                    state_d = SPILL_EMPTY;
                end
            end
            SPILL_FULL: begin
                // No accept possible here: ready is low while full.
                if (drain) begin
                    a_d     = b_q;
                    state_d = SPILL_ONE;
                end
            end
            default: state_d = SPILL_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= SPILL_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload slots are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        a_q <= a_d;
        b_q <= b_d;
    end
endmodule

module axi_spill_cut_intf #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    AXI_BUS.Slave                in,
    AXI_BUS.Master               out,
    output logic [CNT_WIDTH-1:0] wr_outst_o,
    output logic [CNT_WIDTH-1:0] rd_outst_o
);
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam int unsigned AW_W   = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 35 + AXI_USER_WIDTH;
    localparam int unsigned W_W    = AXI_DATA_WIDTH + STRB_W + 1 + AXI_USER_WIDTH;
    localparam int unsigned B_W    = AXI_ID_WIDTH + 2 + AXI_USER_WIDTH;
    localparam int unsigned AR_W   = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 29 + AXI_USER_WIDTH;
    localparam int unsigned R_W    = AXI_ID_WIDTH + AXI_DATA_WIDTH + 3 + AXI_USER_WIDTH;

    logic [AW_W-1:0] aw_src, aw_dst;
    logic [W_W-1:0]  w_src,  w_dst;
    logic [B_W-1:0]  b_src,  b_dst;
    logic [AR_W-1:0] ar_src, ar_dst;
    logic [R_W-1:0]  r_src,  r_dst;

    // ---------------- AW: in -> out ----------------
    assign aw_src = {in.aw_id, in.aw_addr, in.aw_len, in.aw_size, in.aw_burst,
                     in.aw_lock, in.aw_cache, in.aw_prot, in.aw_qos,
                     in.aw_region, in.aw_atop, in.aw_user};
    assign {out.aw_id, out.aw_addr, out.aw_len, out.aw_size, out.aw_burst,
            out.aw_lock, out.aw_cache, out.aw_prot, out.aw_qos,
            out.aw_region, out.aw_atop, out.aw_user} = aw_dst;

    axi_spill_cut_reg #(.W(AW_W)) i_aw_spill (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .src_valid_i (in.aw_valid),
        .src_ready_o (in.aw_ready),
        .src_data_i  (aw_src),
        .dst_valid_o (out.aw_valid),
        .dst_ready_i (out.aw_ready),
        .dst_data_o  (aw_dst)
    );

    // ---------------- W: in -> out ----------------
    assign w_src = {in.w_data, in.w_strb, in.w_last, in.w_user};
    assign {out.w_data, out.w_strb, out.w_last, out.w_user} = w_dst;

    axi_spill_cut_reg #(.W(W_W)) i_w_spill (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .src_valid_i (in.w_valid),
        .src_ready_o (in.w_ready),
        .src_data_i  (w_src),
        .dst_valid_o (out.w_valid),
        .dst_ready_i (out.w_ready),
        .dst_data_o  (w_dst)
    );

    // ---------------- B: out -> in ----------------
    assign b_src = {out.b_id, out.b_resp, out.b_user};
    assign {in.b_id, in.b_resp, in.b_user} = b_dst;

    axi_spill_cut_reg #(.W(B_W)) i_b_spill (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .src_valid_i (out.b_valid),
        .src_ready_o (out.b_ready),
        .src_data_i  (b_src),
        .dst_valid_o (in.b_valid),
        .dst_ready_i (in.b_ready),
        .dst_data_o  (b_dst)
    );

    // ---------------- AR: in -> out ----------------
    assign ar_src = {in.ar_id, in.ar_addr, in.ar_len, in.ar_size, in.ar_burst,
                     in.ar_lock, in.ar_cache, in.ar_prot, in.ar_qos,
                     in.ar_region, in.ar_user};
    assign {out.ar_id, out.ar_addr, out.ar_len, out.ar_size, out.ar_burst,
            out.ar_lock, out.ar_cache, out.ar_prot, out.ar_qos,
            out.ar_region, out.ar_user} = ar_dst;

    axi_spill_cut_reg #(.W(AR_W)) i_ar_spill (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .src_valid_i (in.ar_valid),
        .src_ready_o (in.ar_ready),
        .src_data_i  (ar_src),
        .dst_valid_o (out.ar_valid),
        .dst_ready_i (out.ar_ready),
        .dst_data_o  (ar_dst)
    );

    // ---------------- R: out -> in ----------------
    assign r_src = {out.r_id, out.r_data, out.r_resp, out.r_last, out.r_user};
    assign {in.r_id, in.r_data, in.r_resp, in.r_last, in.r_user} = r_dst;

    axi_spill_cut_reg #(.W(R_W)) i_r_spill (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .src_valid_i (out.r_valid),
        .src_ready_o (out.r_ready),
        .src_data_i  (r_src),
        .dst_valid_o (in.r_valid),
        .dst_ready_i (in.r_ready),
        .dst_data_o  (r_dst)
    );

    // ---------------- Outstanding-transaction counters ----------------
`ifdef AXI_SPILL_CUT_CNT_EN
    logic [CNT_WIDTH-1:0] wr_outst_q, wr_outst_d;
    logic [CNT_WIDTH-1:0] rd_outst_q, rd_outst_d;
    logic                 wr_inc, wr_dec, rd_inc, rd_dec;

    assign wr_inc = out.aw_valid & out.aw_ready;
    assign wr_dec = in.b_valid & in.b_ready;
    assign rd_inc = out.ar_valid & out.ar_ready;
    assign rd_dec = in.r_valid & in.r_ready & in.r_last;

    // Saturating up/down; a simultaneous inc and dec cancel.
    always_comb begin
        wr_outst_d = wr_outst_q;
        rd_outst_d = rd_outst_q;
        if (wr_inc && !wr_dec && (wr_outst_q != '1)) begin
            wr_outst_d = wr_outst_q + 1'b1;
        end else if (!wr_inc && wr_dec && (wr_outst_q != '0)) begin
            wr_outst_d = wr_outst_q - 1'b1;
        end
        if (rd_inc && !rd_dec && (rd_outst_q != '1)) begin
            rd_outst_d = rd_outst_q + 1'b1;
        end else if (!rd_inc && rd_dec && (rd_outst_q != '0)) begin
            rd_outst_d = rd_outst_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_outst_q <= '0;
            rd_outst_q <= '0;
        end else begin
            wr_outst_q <= wr_outst_d;
            rd_outst_q <= rd_outst_d;
        end
    end

    assign wr_outst_o = wr_outst_q;
    assign rd_outst_o = rd_outst_q;

`ifndef SYNTHESIS
    a_wr_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(wr_dec && !wr_inc && (wr_outst_q == '0)))
        else $error("wr_outst decremented at zero");
    a_rd_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rd_dec && !rd_inc && (rd_outst_q == '0)))
        else $error("rd_outst decremented at zero");
`endif
`else
    assign wr_outst_o = '0;
    assign rd_outst_o = '0;
`endif
endmodule

// File: tb/tb_axi_spill_cut_intf.sv
module tb_axi_spill_cut_intf;
    localparam int NCH = 5;  // 0:AW 1:W 2:AR 3:B 4:R
`ifdef AXI_SPILL_CUT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         drv_sv [NCH];
    logic         drv_dr [NCH];
    logic [127:0] drv_w  [NCH];
    logic         obs_sr [NCH];
    logic         obs_dv [NCH];
    logic [127:0] obs_w  [NCH];
    logic [7:0]   wr_outst, rd_outst;

    string CN [NCH] = '{"aw", "w", "ar", "b", "r"};

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) in_bus ();
    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) out_bus ();

    axi_spill_cut_intf #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4),
        .AXI_USER_WIDTH(1), .CNT_WIDTH(8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in         (in_bus),
        .out        (out_bus),
        .wr_outst_o (wr_outst),
        .rd_outst_o (rd_outst)
    );

    // AW
    assign in_bus.aw_valid  = drv_sv[0];
    assign out_bus.aw_ready = drv_dr[0];
    assign {in_bus.aw_id, in_bus.aw_addr, in_bus.aw_len, in_bus.aw_size, in_bus.aw_burst,
            in_bus.aw_lock, in_bus.aw_cache, in_bus.aw_prot, in_bus.aw_qos,
            in_bus.aw_region, in_bus.aw_atop, in_bus.aw_user} = drv_w[0][71:0];
    assign obs_sr[0] = in_bus.aw_ready;
    assign obs_dv[0] = out_bus.aw_valid;
    assign obs_w[0]  = 128'({out_bus.aw_id, out_bus.aw_addr, out_bus.aw_len, out_bus.aw_size,
                            out_bus.aw_burst, out_bus.aw_lock, out_bus.aw_cache, out_bus.aw_prot,
                            out_bus.aw_qos, out_bus.aw_region, out_bus.aw_atop, out_bus.aw_user});
    // W  (data at [73:10], last at [1])
    assign in_bus.w_valid  = drv_sv[1];
    assign out_bus.w_ready = drv_dr[1];
    assign {in_bus.w_data, in_bus.w_strb, in_bus.w_last, in_bus.w_user} = drv_w[1][73:0];
    assign obs_sr[1] = in_bus.w_ready;
    assign obs_dv[1] = out_bus.w_valid;
    assign obs_w[1]  = 128'({out_bus.w_data, out_bus.w_strb, out_bus.w_last, out_bus.w_user});
    // AR
    assign in_bus.ar_valid  = drv_sv[2];
    assign out_bus.ar_ready = drv_dr[2];
    assign {in_bus.ar_id, in_bus.ar_addr, in_bus.ar_len, in_bus.ar_size, in_bus.ar_burst,
            in_bus.ar_lock, in_bus.ar_cache, in_bus.ar_prot, in_bus.ar_qos,
            in_bus.ar_region, in_bus.ar_user} = drv_w[2][65:0];
    assign obs_sr[2] = in_bus.ar_ready;
    assign obs_dv[2] = out_bus.ar_valid;
    assign obs_w[2]  = 128'({out_bus.ar_id, out_bus.ar_addr, out_bus.ar_len, out_bus.ar_size,
                            out_bus.ar_burst, out_bus.ar_lock, out_bus.ar_cache, out_bus.ar_prot,
                            out_bus.ar_qos, out_bus.ar_region, out_bus.ar_user});
    // B (flows out -> in)
    assign out_bus.b_valid = drv_sv[3];
    assign in_bus.b_ready  = drv_dr[3];
    assign {out_bus.b_id, out_bus.b_resp, out_bus.b_user} = drv_w[3][6:0];
    assign obs_sr[3] = out_bus.b_ready;
    assign obs_dv[3] = in_bus.b_valid;
    assign obs_w[3]  = 128'({in_bus.b_id, in_bus.b_resp, in_bus.b_user});
    // R (flows out -> in; last at [1])
    assign out_bus.r_valid = drv_sv[4];
    assign in_bus.r_ready  = drv_dr[4];
    assign {out_bus.r_id, out_bus.r_data, out_bus.r_resp, out_bus.r_last, out_bus.r_user} = drv_w[4][71:0];
    assign obs_sr[4] = out_bus.r_ready;
    assign obs_dv[4] = in_bus.r_valid;
    assign obs_w[4]  = 128'({in_bus.r_id, in_bus.r_data, in_bus.r_resp, in_bus.r_last, in_bus.r_user});

    // ---------------- reference model: a bounded FIFO per channel ----------------
    logic [127:0] mq [NCH][$];
    bit           acc_flag [NCH];
    bit           dr_flag  [NCH];
    logic [127:0] dr_word  [NCH];
    int           in_cnt   [NCH];
    int           out_cnt  [NCH];
    int           m_wr, m_rd;
    int           aw_done, b_inj, ar_done, rl_inj;
    int           cyc_n = 0;
    int           n_chk = 0;
    int           n_pass = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int cw(input int c);
        case (c)
            0: return 72;
            1: return 74;
            2: return 66;
            3: return 7;
            default: return 72;
        endcase
    endfunction

    function automatic logic [127:0] rnd(input int c);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r & ((128'd1 << cw(c)) - 128'd1);
    endfunction

    function automatic logic [127:0] wbeat(input int i);
        return {54'd0, 64'(i), 8'hFF, 1'(i == 15), 1'b0};
    endfunction

    function automatic int sat(input int v, input bit inc, input bit dec);
        if (inc && !dec) return (v == 255) ? 255 : v + 1;
        if (dec && !inc) return (v == 0) ? 0 : v - 1;
        return v;
    endfunction

    task automatic model_update();
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                mq[c].delete();
                acc_flag[c] = 0;
                dr_flag[c]  = 0;
                in_cnt[c]   = 0;
                out_cnt[c]  = 0;
            end
            m_wr = 0; m_rd = 0;
            aw_done = 0; b_inj = 0; ar_done = 0; rl_inj = 0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                int s;
                s = mq[c].size();
                acc_flag[c] = drv_sv[c] && (s < 2);
                dr_flag[c]  = drv_dr[c] && (s > 0);
                if (dr_flag[c]) begin
                    dr_word[c] = mq[c].pop_front();
                    out_cnt[c]++;
                end
                if (acc_flag[c]) begin
                    mq[c].push_back(drv_w[c]);
                    in_cnt[c]++;
                end
            end
            m_wr = sat(m_wr, dr_flag[0], dr_flag[3]);
            m_rd = sat(m_rd, dr_flag[2], dr_flag[4] && dr_word[4][1]);
            aw_done += int'(dr_flag[0]);
            b_inj   += int'(acc_flag[3]);
            ar_done += int'(dr_flag[2]);
            rl_inj  += int'(acc_flag[4] && drv_w[4][1]);
        end
        cyc_n++;
    endtask

    task automatic check_all();
        for (int c = 0; c < NCH; c++) begin
            check_eq({CN[c], "_src_ready"}, 128'(obs_sr[c]), 128'(mq[c].size() < 2));
            check_eq({CN[c], "_dst_valid"}, 128'(obs_dv[c]), 128'(mq[c].size() > 0));
            if (mq[c].size() > 0) check_eq({CN[c], "_payload"}, obs_w[c], mq[c][0]);
        end
        check_eq("wr_outst", 128'(wr_outst), CNT_ON ? 128'(m_wr) : 128'd0);
        check_eq("rd_outst", 128'(rd_outst), CNT_ON ? 128'(m_rd) : 128'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        for (int c = 0; c < NCH; c++) begin
            drv_sv[c] = 1'b0;
            drv_dr[c] = 1'b1;
            drv_w[c]  = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int i, n_out, sent, got, first_in, last_out, cyc;
        logic [127:0] wd;

        idle();
        do_reset();
        for (int c = 0; c < NCH; c++) begin
            check_eq({CN[c], "_reset_valid"}, 128'(obs_dv[c]), 128'd0);
            check_eq({CN[c], "_reset_ready"}, 128'(obs_sr[c]), 128'd1);
        end

        // single AW beat: one cycle latency, ready stays high
        wd = rnd(0);
        drv_sv[0] = 1'b1; drv_w[0] = wd;
        step();
        drv_sv[0] = 1'b0;
        check_eq("aw_lat_valid", 128'(obs_dv[0]), 128'd1);
        check_eq("aw_lat_word", obs_w[0], wd);
        check_eq("aw_lat_ready", 128'(obs_sr[0]), 128'd1);
        step();

        // 16 W beats against a blocked sink
        drv_dr[1] = 1'b0;
        i = 0;
        for (int k = 0; k < 8; k++) begin
            drv_sv[1] = 1'b1; drv_w[1] = wbeat(i);
            step();
            if (acc_flag[1]) i++;
        end
        check_eq("w_accepted_blocked", 128'(i), 128'd2);
        check_eq("w_ready_low", 128'(obs_sr[1]), 128'd0);
        drv_dr[1] = 1'b1;
        n_out = 0;
        for (cyc = 0; cyc < 100 && n_out < 16; cyc++) begin
            drv_sv[1] = (i < 16); drv_w[1] = wbeat(i);
            step();
            if (acc_flag[1]) i++;
            if (dr_flag[1]) begin
                check_eq("w_order", 128'(dr_word[1][73:10]), 128'(n_out));
                n_out++;
            end
        end
        drv_sv[1] = 1'b0;
        check_eq("w_count", 128'(n_out), 128'd16);
        check_eq("w_release_cycles", 128'(cyc), 128'd16);

        // R throughput, both sides always ready
        sent = 0; got = 0; first_in = -1; last_out = -1;
        for (int k = 0; k < 400 && got < 256; k++) begin
            drv_sv[4] = (sent < 256);
            wd = rnd(4); wd[1] = 1'b0;
            drv_w[4] = wd;
            step();
            if (acc_flag[4]) begin
                if (sent == 0) first_in = cyc_n;
                sent++;
            end
            if (dr_flag[4]) begin
                got++;
                last_out = cyc_n;
            end
        end
        drv_sv[4] = 1'b0;
        check_eq("r_beats", 128'(got), 128'd256);
        check_eq("r_span", 128'(last_out - first_in), 128'd256);

        // reset while AR spill is full
        drv_dr[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drv_sv[2] = 1'b1; drv_w[2] = rnd(2);
            step();
        end
        check_eq("ar_full_ready", 128'(obs_sr[2]), 128'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("ar_rst_valid", 128'(obs_dv[2]), 128'd0);
        check_eq("ar_rst_ready", 128'(obs_sr[2]), 128'd1);
        wd = rnd(2);
        drv_sv[2] = 1'b1; drv_w[2] = wd;
        step();
        drv_sv[2] = 1'b0;
        check_eq("ar_post_rst_word", obs_w[2], wd);
        drv_dr[2] = 1'b1;
        step();

        // outstanding counters
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drv_sv[0] = 1'b1; drv_w[0] = rnd(0);
            step();
        end
        drv_sv[0] = 1'b0;
        step(); step();
        drv_sv[3] = 1'b1; drv_w[3] = rnd(3);
        step();
        drv_sv[3] = 1'b0;
        step();
        check_eq("wr_outst_3aw_1b", 128'(wr_outst), CNT_ON ? 128'd2 : 128'd0);
        drv_sv[2] = 1'b1; drv_w[2] = rnd(2);
        step();
        drv_sv[2] = 1'b0;
        step();
        check_eq("rd_outst_after_ar", 128'(rd_outst), CNT_ON ? 128'd1 : 128'd0);
        for (int n = 0; n < 4; n++) begin
            wd = rnd(4); wd[1] = (n == 3);
            drv_sv[4] = 1'b1; drv_w[4] = wd;
            step();
            drv_sv[4] = 1'b0;
            step();
            check_eq("rd_outst_r_beat", 128'(rd_outst), (CNT_ON && n < 3) ? 128'd1 : 128'd0);
        end

        // random valid/ready toggling on all channels
        for (int k = 0; k < 1000; k++) begin
            for (int c = 0; c < NCH; c++) begin
                drv_sv[c] = 1'($urandom_range(0, 1));
                drv_dr[c] = 1'($urandom_range(0, 1));
                drv_w[c]  = rnd(c);
            end
            // never let B or a last R overtake the requests they answer
            drv_sv[3] = ($urandom_range(0, 3) != 0) && (b_inj < aw_done);
            if (!(($urandom_range(0, 3) == 0) && (rl_inj < ar_done))) drv_w[4][1] = 1'b0;
            step();
        end

        idle();
        for (int k = 0; k < 4; k++) step();
        for (int c = 0; c < NCH; c++)
            check_eq({CN[c], "_scoreboard_in_eq_out"}, 128'(out_cnt[c]), 128'(in_cnt[c]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
